wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, name, default and meaning:
- XLEN, 64, data width.
- ROB_INDEX_WIDTH, 4, ROB tag width.
- PHY_REG_ADDR_WIDTH, 6, physical register address width.
- PC_WIDTH, 32, PC width.
- FIFO_DEPTH, 4, entries per source FIFO (power of 2, ≥2).

REQ-002 Ports SHALL be, one per line, name, direction, width and meaning (`{1,2}` means one port per ALU):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; discard all buffered results.
- alu{1,2}_vld_i  in  1  ALU result valid; no back-pressure.
- alu{1,2}_rob_index_i  in  ROB_INDEX_WIDTH  ROB tag.
- alu{1,2}_prd_addr_i  in  PHY_REG_ADDR_WIDTH  destination physical register.
- alu{1,2}_data_i  in  XLEN  writeback data.
- alu{1,2}_branch_miss_i  in  1  mispredict flag.
- alu{1,2}_final_next_pc_i  in  PC_WIDTH  resolved next PC.
- lsu_vld_i  in  1  LSU result valid.
- lsu_rob_index_i  in  ROB_INDEX_WIDTH  ROB tag.
- lsu_rd_addr_i  in  PHY_REG_ADDR_WIDTH  destination physical register.
- lsu_data_i  in  XLEN  load data.
- lsu_rdy_o  out  1  LSU FIFO can accept an entry.
- alu{1,2}_stall_o  out  1  ALU FIFO nearly full; issue must hold.
- overflow_o  out  1  sticky error: an ALU push was dropped.
- wb{0,1}_vld_o  out  1  writeback port valid.
- wb{0,1}_rob_index_o  out  ROB_INDEX_WIDTH  ROB tag.
- wb{0,1}_prd_addr_o  out  PHY_REG_ADDR_WIDTH  destination physical register.
- wb{0,1}_data_o  out  XLEN  writeback data.
- wb{0,1}_branch_miss_o  out  1  mispredict flag.
- wb{0,1}_final_next_pc_o  out  PC_WIDTH  resolved next PC.

REQ-003 The block SHALL use one clock `clk`; reset `rst` is asynchronous and active-high.

Function
REQ-004 The block SHALL contain three independent FIFOs (source 0 = ALU1, 1 = ALU2, 2 = LSU), each of FIFO_DEPTH entries, with read and write pointers that wrap modulo FIFO_DEPTH and an occupancy count.

REQ-005 An LSU entry SHALL be pushed only when lsu_vld_i and lsu_rdy_o are both 1; LSU entries store branch_miss=0 and final_next_pc=0.

REQ-006 lsu_rdy_o SHALL equal (LSU count < FIFO_DEPTH), computed from registered state only.

REQ-007 alu{n}_stall_o SHALL equal (ALU{n} count ≥ FIFO_DEPTH-1), computed from registered state only.

REQ-008 An ALU push into a full FIFO SHALL be dropped and SHALL set overflow_o on the next edge; overflow_o stays 1 until rst.

REQ-009 Each cycle the arbiter SHALL grant up to two non-empty sources:
- search order starts at rr_ptr (2 bits, values 0..2) and proceeds rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3;
- the first granted source drives port wb0, the second drives port wb1;
- a granted FIFO pops its head entry that cycle.

REQ-010 After any grant, rr_ptr SHALL advance to (last granted source + 1) mod 3; with no grant, rr_ptr holds.

REQ-011 wb ports SHALL be registered:
- a grant at edge N makes wb{k}_vld_o=1 with the entry's fields for cycle N+1;
- an ungranted port drives vld=0 with all fields 0.

REQ-012 Minimum latency SHALL be one cycle, meaning:
- an entry pushed at edge N is eligible for grant in cycle N+1 and appears on a wb port after edge N+1;
- there is no same-cycle bypass.

REQ-013 Simultaneous push and pop on one FIFO SHALL both take effect, with count unchanged; a pop from a full FIFO in the same cycle as a push does not count as overflow.

REQ-014 Ordering within a source SHALL be FIFO order; no ordering is guaranteed across sources.

REQ-015 flush_i=1 at an edge SHALL:
- clear all FIFO pointers and counts;
- force both wb{k}_vld_o to 0 on the next cycle;
- drop any same-cycle pushes;
- perform no grant;
- leave rr_ptr and overflow_o unchanged.

Reset
REQ-016 While rst=1, the block SHALL hold the following:
- all FIFOs empty;
- rr_ptr=0;
- wb{0,1}_vld_o=0 with all wb fields 0;
- overflow_o=0, lsu_rdy_o=1, alu{1,2}_stall_o=0.

REQ-017 An asynchronous rst assertion mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.

REQ-018 Normal operation SHALL resume at the first rising edge after rst deasserts.

Verification
REQ-019 Single source: alu1 pushes rob=3, data=0x55 at edge 1 → wb0_vld_o=1, rob=3, data=0x55 after edge 2; wb1_vld_o=0.

REQ-020 Three-way contention: all three sources push at edge 1 with rr_ptr=0 → after edge 2, wb0=ALU1 and wb1=ALU2, rr_ptr=2 → after edge 3, wb0=LSU.

REQ-021 Full and stall: alu2 pushes 4 consecutive cycles with no grant possible (all ports busy) → alu2_stall_o=1 at count 3; a 5th push sets overflow_o=1, and it stays 1.

REQ-022 LSU back-pressure: fill the LSU FIFO → lsu_rdy_o=0; lsu_vld_i=1 is ignored until a pop, then lsu_rdy_o=1 in the next cycle.

REQ-023 Flush: 3 entries buffered, flush_i plus a new push at edge N → all counts 0 after edge N; wb vld=0 after edge N; no output in cycle N+1.

REQ-024 Asynchronous reset: assert rst between clock edges with FIFOs non-empty → all outputs reach their reset values before the next edge; lsu_rdy_o=1.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Collects results from two ALUs and one LSU into three small FIFOs and
//   drains them onto two registered writeback ports. Each cycle it grants up to
//   two non-empty sources in round-robin order.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   flush_i                : discard every buffered result
//   alu{1,2}_*_i           : ALU result (no back-pressure)
//   alu{1,2}_stall_o       : ALU FIFO holds FIFO_DEPTH-1 or more entries
//   lsu_*_i / lsu_rdy_o    : LSU result with ready handshake
//   overflow_o             : sticky, an ALU result was dropped into a full FIFO
//   wb{0,1}_*_o            : registered writeback ports
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int XLEN               = 64,
   parameter int ROB_INDEX_WIDTH    = 4,
   parameter int PHY_REG_ADDR_WIDTH = 6,
   parameter int PC_WIDTH           = 32,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic                          alu1_vld_i,
   input  logic [ROB_INDEX_WIDTH-1:0]    alu1_rob_index_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] alu1_prd_addr_i,
   input  logic [XLEN-1:0]               alu1_data_i,
   input  logic                          alu1_branch_miss_i,
   input  logic [PC_WIDTH-1:0]           alu1_final_next_pc_i,
   input  logic                          alu2_vld_i,
   input  logic [ROB_INDEX_WIDTH-1:0]    alu2_rob_index_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] alu2_prd_addr_i,
   input  logic [XLEN-1:0]               alu2_data_i,
   input  logic                          alu2_branch_miss_i,
   input  logic [PC_WIDTH-1:0]           alu2_final_next_pc_i,
   input  logic                          lsu_vld_i,
   input  logic [ROB_INDEX_WIDTH-1:0]    lsu_rob_index_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] lsu_rd_addr_i,
   input  logic [XLEN-1:0]               lsu_data_i,
   output logic                          lsu_rdy_o,
   output logic                          alu1_stall_o,
   output logic                          alu2_stall_o,
   output logic                          overflow_o,
   output logic                          wb0_vld_o,
   output logic [ROB_INDEX_WIDTH-1:0]    wb0_rob_index_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] wb0_prd_addr_o,
   output logic [XLEN-1:0]               wb0_data_o,
   output logic                          wb0_branch_miss_o,
   output logic [PC_WIDTH-1:0]           wb0_final_next_pc_o,
   output logic                          wb1_vld_o,
   output logic [ROB_INDEX_WIDTH-1:0]    wb1_rob_index_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] wb1_prd_addr_o,
   output logic [XLEN-1:0]               wb1_data_o,
   output logic                          wb1_branch_miss_o,
   output logic [PC_WIDTH-1:0]           wb1_final_next_pc_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] NEAR_C  = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

   typedef struct packed {
      logic [ROB_INDEX_WIDTH-1:0]    rob;
      logic [PHY_REG_ADDR_WIDTH-1:0] prd;
      logic [XLEN-1:0]               data;
      logic                          bm;
      logic [PC_WIDTH-1:0]           pc;
   } entry_t;

   // Wraps a small sum back into the source range 0..2.
   function automatic logic [1:0] wrap3(input logic [2:0] v);
      wrap3 = (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   entry_t               mem_q    [0:2][0:FIFO_DEPTH-1];
   entry_t               mem_d    [0:2][0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]     wr_ptr_q [0:2];
   logic [PTR_W-1:0]     wr_ptr_d [0:2];
   logic [PTR_W-1:0]     rd_ptr_q [0:2];
   logic [PTR_W-1:0]     rd_ptr_d [0:2];
   logic [CNT_W-1:0]     cnt_q    [0:2];
   logic [CNT_W-1:0]     cnt_d    [0:2];
   logic [1:0]           rr_q, rr_d;
   logic                 overflow_q, overflow_d;
   logic                 lsu_rdy_q, lsu_rdy_d;
   logic                 alu1_stall_q, alu1_stall_d;
   logic                 alu2_stall_q, alu2_stall_d;
   logic [1:0]           wb_vld_q, wb_vld_d;
   entry_t               wb_q [0:1];
   entry_t               wb_d [0:1];

   entry_t               in_entry_s [0:2];
   logic [2:0]           in_vld_s, push_s, pop_s, drop_s;
   logic [1:0]           src_s, last_s, n_grant_s;
   logic                 any_grant_s;

   // Gather the three incoming results into a common entry format.
   always_comb begin
      in_entry_s[0] = {alu1_rob_index_i, alu1_prd_addr_i, alu1_data_i,
                       alu1_branch_miss_i, alu1_final_next_pc_i};
      in_entry_s[1] = {alu2_rob_index_i, alu2_prd_addr_i, alu2_data_i,
                       alu2_branch_miss_i, alu2_final_next_pc_i};
      in_entry_s[2] = {lsu_rob_index_i, lsu_rd_addr_i, lsu_data_i,
                       1'b0, {PC_WIDTH{1'b0}}};
      in_vld_s      = {lsu_vld_i, alu2_vld_i, alu1_vld_i};
   end

   // Round-robin grant of up to two sources, starting at rr_q.
   always_comb begin
      pop_s       = 3'b000;
      wb_vld_d    = 2'b00;
      wb_d[0]     = '0;
      wb_d[1]     = '0;
      n_grant_s   = 2'd0;
      last_s      = rr_q;
      any_grant_s = 1'b0;
      src_s       = 2'd0;
      for (int k = 0; k < 3; k++) begin
         src_s = wrap3({1'b0, rr_q} + 3'(k));
         if (!flush_i && (cnt_q[src_s] != ZERO_C) && (n_grant_s != 2'd2)) begin
            pop_s[src_s]           = 1'b1;
            wb_vld_d[n_grant_s[0]] = 1'b1;
            wb_d[n_grant_s[0]]     = mem_q[src_s][rd_ptr_q[src_s]];
            n_grant_s              = n_grant_s + 2'd1;
            last_s                 = src_s;
            any_grant_s            = 1'b1;
         end else begin
            any_grant_s = any_grant_s;
         end
      end
      if (any_grant_s) begin
         rr_d = (last_s == 2'd2) ? 2'd0 : last_s + 2'd1;
      end else begin
         rr_d = rr_q;
      end
   end

   // FIFO push/pop bookkeeping and derived status flags.
   always_comb begin
      mem_d = mem_q;
      for (int s = 0; s < 3; s++) begin
         // An ALU may push into a full FIFO only if its head leaves this cycle.
         if (s == 2) begin
            push_s[s] = lsu_vld_i & lsu_rdy_q & ~flush_i;
            drop_s[s] = 1'b0;
         end else begin
            push_s[s] = in_vld_s[s] & ((cnt_q[s] != DEPTH_C) | pop_s[s]) & ~flush_i;
            drop_s[s] = in_vld_s[s] & (cnt_q[s] == DEPTH_C) & ~pop_s[s] & ~flush_i;
         end
         mem_d[s][wr_ptr_q[s]] = push_s[s] ? in_entry_s[s] : mem_q[s][wr_ptr_q[s]];
         if (flush_i) begin
            wr_ptr_d[s] = {PTR_W{1'b0}};
            rd_ptr_d[s] = {PTR_W{1'b0}};
            cnt_d[s]    = ZERO_C;
         end else begin
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push_s[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop_s[s]);
            cnt_d[s]    = cnt_q[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
         end
      end
      overflow_d   = overflow_q | (|drop_s);
      lsu_rdy_d    = (cnt_d[2] < DEPTH_C);
      alu1_stall_d = (cnt_d[0] >= NEAR_C);
      alu2_stall_d = (cnt_d[1] >= NEAR_C);
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 3; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               mem_q[s][e] <= '0;
            end
            wr_ptr_q[s] <= {PTR_W{1'b0}};
            rd_ptr_q[s] <= {PTR_W{1'b0}};
            cnt_q[s]    <= ZERO_C;
         end
         rr_q         <= 2'd0;
         overflow_q   <= 1'b0;
         lsu_rdy_q    <= 1'b1;
         alu1_stall_q <= 1'b0;
         alu2_stall_q <= 1'b0;
         wb_vld_q     <= 2'b00;
         wb_q[0]      <= '0;
         wb_q[1]      <= '0;
      end else begin
         for (int s = 0; s < 3; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               mem_q[s][e] <= mem_d[s][e];
            end
            wr_ptr_q[s] <= wr_ptr_d[s];
            rd_ptr_q[s] <= rd_ptr_d[s];
            cnt_q[s]    <= cnt_d[s];
         end
         rr_q         <= rr_d;
         overflow_q   <= overflow_d;
         lsu_rdy_q    <= lsu_rdy_d;
         alu1_stall_q <= alu1_stall_d;
         alu2_stall_q <= alu2_stall_d;
         wb_vld_q     <= wb_vld_d;
         wb_q[0]      <= wb_d[0];
         wb_q[1]      <= wb_d[1];
      end
   end

   assign lsu_rdy_o           = lsu_rdy_q;
   assign alu1_stall_o        = alu1_stall_q;
   assign alu2_stall_o        = alu2_stall_q;
   assign overflow_o          = overflow_q;
   assign wb0_vld_o           = wb_vld_q[0];
   assign wb0_rob_index_o     = wb_q[0].rob;
   assign wb0_prd_addr_o      = wb_q[0].prd;
   assign wb0_data_o          = wb_q[0].data;
   assign wb0_branch_miss_o   = wb_q[0].bm;
   assign wb0_final_next_pc_o = wb_q[0].pc;
   assign wb1_vld_o           = wb_vld_q[1];
   assign wb1_rob_index_o     = wb_q[1].rob;
   assign wb1_prd_addr_o      = wb_q[1].prd;
   assign wb1_data_o          = wb_q[1].data;
   assign wb1_branch_miss_o   = wb_q[1].bm;
   assign wb1_final_next_pc_o = wb_q[1].pc;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter: a queue-based model predicts every
//   output each cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  rob;
      logic [5:0]  prd;
      logic [63:0] data;
      logic        bm;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic        alu1_vld_i = 1'b0, alu2_vld_i = 1'b0, lsu_vld_i = 1'b0;
   logic [3:0]  alu1_rob_index_i = 4'd0, alu2_rob_index_i = 4'd0, lsu_rob_index_i = 4'd0;
   logic [5:0]  alu1_prd_addr_i = 6'd0, alu2_prd_addr_i = 6'd0, lsu_rd_addr_i = 6'd0;
   logic [63:0] alu1_data_i = 64'd0, alu2_data_i = 64'd0, lsu_data_i = 64'd0;
   logic        alu1_branch_miss_i = 1'b0, alu2_branch_miss_i = 1'b0;
   logic [31:0] alu1_final_next_pc_i = 32'd0, alu2_final_next_pc_i = 32'd0;
   logic        lsu_rdy_o, alu1_stall_o, alu2_stall_o, overflow_o;
   logic        wb0_vld_o, wb1_vld_o;
   logic [3:0]  wb0_rob_index_o, wb1_rob_index_o;
   logic [5:0]  wb0_prd_addr_o, wb1_prd_addr_o;
   logic [63:0] wb0_data_o, wb1_data_o;
   logic        wb0_branch_miss_o, wb1_branch_miss_o;
   logic [31:0] wb0_final_next_pc_o, wb1_final_next_pc_o;

   int n_checks = 0;
   int n_errors = 0;

   wb_arbiter #(.XLEN(64), .ROB_INDEX_WIDTH(4), .PHY_REG_ADDR_WIDTH(6),
                .PC_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .alu1_vld_i(alu1_vld_i), .alu1_rob_index_i(alu1_rob_index_i),
      .alu1_prd_addr_i(alu1_prd_addr_i), .alu1_data_i(alu1_data_i),
      .alu1_branch_miss_i(alu1_branch_miss_i), .alu1_final_next_pc_i(alu1_final_next_pc_i),
      .alu2_vld_i(alu2_vld_i), .alu2_rob_index_i(alu2_rob_index_i),
      .alu2_prd_addr_i(alu2_prd_addr_i), .alu2_data_i(alu2_data_i),
      .alu2_branch_miss_i(alu2_branch_miss_i), .alu2_final_next_pc_i(alu2_final_next_pc_i),
      .lsu_vld_i(lsu_vld_i), .lsu_rob_index_i(lsu_rob_index_i),
      .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_data_i(lsu_data_i), .lsu_rdy_o(lsu_rdy_o),
      .alu1_stall_o(alu1_stall_o), .alu2_stall_o(alu2_stall_o), .overflow_o(overflow_o),
      .wb0_vld_o(wb0_vld_o), .wb0_rob_index_o(wb0_rob_index_o),
      .wb0_prd_addr_o(wb0_prd_addr_o), .wb0_data_o(wb0_data_o),
      .wb0_branch_miss_o(wb0_branch_miss_o), .wb0_final_next_pc_o(wb0_final_next_pc_o),
      .wb1_vld_o(wb1_vld_o), .wb1_rob_index_o(wb1_rob_index_o),
      .wb1_prd_addr_o(wb1_prd_addr_o), .wb1_data_o(wb1_data_o),
      .wb1_branch_miss_o(wb1_branch_miss_o), .wb1_final_next_pc_o(wb1_final_next_pc_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   ent_t mq [3][$];
   int   m_rr  = 0;
   logic m_ovf = 1'b0;
   logic [1:0] exp_vld = 2'b00;
   ent_t exp_wb [2];
   logic exp_rdy = 1'b1, exp_st1 = 1'b0, exp_st2 = 1'b0;
   int   sz [3];
   int   ng, last, src;
   ent_t in_e [3];

   initial begin
      exp_wb[0] = '0;
      exp_wb[1] = '0;
   end

   // Model update: grants come from what was buffered before this edge.
   always @(posedge clk or posedge rst) begin
      exp_vld   = 2'b00;
      exp_wb[0] = '0;
      exp_wb[1] = '0;
      if (rst) begin
         for (int s = 0; s < 3; s++) mq[s].delete();
         m_rr  = 0;
         m_ovf = 1'b0;
      end else if (flush_i) begin
         for (int s = 0; s < 3; s++) mq[s].delete();
      end else begin
         in_e[0] = '{alu1_rob_index_i, alu1_prd_addr_i, alu1_data_i, alu1_branch_miss_i, alu1_final_next_pc_i};
         in_e[1] = '{alu2_rob_index_i, alu2_prd_addr_i, alu2_data_i, alu2_branch_miss_i, alu2_final_next_pc_i};
         in_e[2] = '{lsu_rob_index_i, lsu_rd_addr_i, lsu_data_i, 1'b0, 32'd0};
         for (int s = 0; s < 3; s++) sz[s] = mq[s].size();
         ng = 0;
         last = -1;
         for (int k = 0; k < 3; k++) begin
            src = (m_rr + k) % 3;
            if (ng < 2 && sz[src] > 0) begin
               exp_wb[ng]  = mq[src].pop_front();
               exp_vld[ng] = 1'b1;
               ng++;
               last = src;
            end
         end
         if (last >= 0) m_rr = (last + 1) % 3;
         if (alu1_vld_i) begin
            if (mq[0].size() < DEPTH) mq[0].push_back(in_e[0]); else m_ovf = 1'b1;
         end
         if (alu2_vld_i) begin
            if (mq[1].size() < DEPTH) mq[1].push_back(in_e[1]); else m_ovf = 1'b1;
         end
         if (lsu_vld_i && sz[2] < DEPTH) mq[2].push_back(in_e[2]);
      end
      exp_rdy = (mq[2].size() < DEPTH);
      exp_st1 = (mq[0].size() >= DEPTH - 1);
      exp_st2 = (mq[1].size() >= DEPTH - 1);
   end

   // Compare every DUT output against the model shortly after each edge.
   always @(posedge clk) begin
      #1;
      chk("wb0_vld", wb0_vld_o, exp_vld[0]);
      chk("wb0_fields", {wb0_rob_index_o, wb0_prd_addr_o, wb0_data_o, wb0_branch_miss_o, wb0_final_next_pc_o}, exp_wb[0]);
      chk("wb1_vld", wb1_vld_o, exp_vld[1]);
      chk("wb1_fields", {wb1_rob_index_o, wb1_prd_addr_o, wb1_data_o, wb1_branch_miss_o, wb1_final_next_pc_o}, exp_wb[1]);
      chk("lsu_rdy", lsu_rdy_o, exp_rdy);
      chk("alu1_stall", alu1_stall_o, exp_st1);
      chk("alu2_stall", alu2_stall_o, exp_st2);
      chk("overflow", overflow_o, m_ovf);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      alu1_vld_i = 1'b0;
      alu2_vld_i = 1'b0;
      lsu_vld_i  = 1'b0;
   endtask

   task automatic drive(input int s, input logic [3:0] rob, input logic [5:0] prd,
                        input logic [63:0] data, input logic bm, input logic [31:0] pc);
      case (s)
         0: begin
            alu1_vld_i = 1'b1; alu1_rob_index_i = rob; alu1_prd_addr_i = prd;
            alu1_data_i = data; alu1_branch_miss_i = bm; alu1_final_next_pc_i = pc;
         end
         1: begin
            alu2_vld_i = 1'b1; alu2_rob_index_i = rob; alu2_prd_addr_i = prd;
            alu2_data_i = data; alu2_branch_miss_i = bm; alu2_final_next_pc_i = pc;
         end
         default: begin
            lsu_vld_i = 1'b1; lsu_rob_index_i = rob; lsu_rd_addr_i = prd; lsu_data_i = data;
         end
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("reset_rdy", lsu_rdy_o, 1'b1);
      chk("reset_wb0_vld", wb0_vld_o, 1'b0);
      rst = 1'b0;

      // Single source: one-cycle latency, lands on wb0.
      drive(0, 4'd3, 6'd7, 64'h55, 1'b0, 32'h100);
      step();
      idle();
      chk("single_latency_vld", wb0_vld_o, 1'b0);
      step();
      chk("single_wb0_vld", wb0_vld_o, 1'b1);
      chk("single_wb0_rob", wb0_rob_index_o, 4'd3);
      chk("single_wb0_data", wb0_data_o, 64'h55);
      chk("single_wb0_prd", wb0_prd_addr_o, 6'd7);
      chk("single_wb1_vld", wb1_vld_o, 1'b0);
      step();

      // Three-way contention starting from rr_ptr=0.
      do_reset();
      drive(0, 4'd1, 6'd11, 64'h1111, 1'b1, 32'h1000);
      drive(1, 4'd2, 6'd12, 64'h2222, 1'b0, 32'h2000);
      drive(2, 4'd5, 6'd9, 64'hABCD, 1'b0, 32'h0);
      step();
      idle();
      step();
      chk("c3_wb0_rob", wb0_rob_index_o, 4'd1);
      chk("c3_wb0_bm", wb0_branch_miss_o, 1'b1);
      chk("c3_wb0_pc", wb0_final_next_pc_o, 32'h1000);
      chk("c3_wb1_vld", wb1_vld_o, 1'b1);
      chk("c3_wb1_rob", wb1_rob_index_o, 4'd2);
      step();
      chk("c3_lsu_vld", wb0_vld_o, 1'b1);
      chk("c3_lsu_rob", wb0_rob_index_o, 4'd5);
      chk("c3_lsu_data", wb0_data_o, 64'hABCD);
      chk("c3_lsu_bm_pc", {wb0_branch_miss_o, wb0_final_next_pc_o}, 33'd0);
      chk("c3_wb1_idle", wb1_vld_o, 1'b0);

      // Continuous pushes on all three sources: fill, stall, overflow, LSU back-pressure.
      for (int i = 0; i < 14; i++) begin
         drive(0, 4'(i), 6'(i), 64'h1000 + 64'(i), 1'(i), 32'h40 + 32'(i));
         drive(1, 4'(i + 3), 6'(i + 20), 64'h2000 + 64'(i), 1'(i + 1), 32'h80 + 32'(i));
         drive(2, 4'(i + 7), 6'(i + 40), 64'h3000 + 64'(i), 1'b0, 32'h0);
         step();
      end
      idle();
      chk("full_overflow", overflow_o, 1'b1);
      chk("full_alu2_stall", alu2_stall_o, 1'b1);
      chk("full_lsu_rdy", lsu_rdy_o, 1'b0);
      step();
      chk("lsu_rdy_after_pop", lsu_rdy_o, 1'b1);
      for (int i = 0; i < 10; i++) step();
      chk("overflow_sticky", overflow_o, 1'b1);
      chk("drained_alu2_stall", alu2_stall_o, 1'b0);

      // Flush with a same-cycle push.
      drive(0, 4'd1, 6'd1, 64'hA1, 1'b0, 32'h4);
      drive(1, 4'd2, 6'd2, 64'hA2, 1'b0, 32'h8);
      drive(2, 4'd3, 6'd3, 64'hA3, 1'b0, 32'h0);
      step();
      flush_i = 1'b1;
      drive(0, 4'd4, 6'd4, 64'hB1, 1'b0, 32'hC);
      step();
      flush_i = 1'b0;
      idle();
      chk("flush_wb_vld", {wb0_vld_o, wb1_vld_o}, 2'b00);
      chk("flush_lsu_rdy", lsu_rdy_o, 1'b1);
      chk("flush_stalls", {alu1_stall_o, alu2_stall_o}, 2'b00);
      chk("flush_keeps_overflow", overflow_o, 1'b1);
      step();
      chk("flush_next_idle", {wb0_vld_o, wb1_vld_o}, 2'b00);

      // Asynchronous reset between edges with FIFOs non-empty.
      drive(0, 4'd6, 6'd6, 64'hC1, 1'b0, 32'h10);
      drive(1, 4'd7, 6'd7, 64'hC2, 1'b1, 32'h14);
      drive(2, 4'd8, 6'd8, 64'hC3, 1'b0, 32'h0);
      step();
      step();
      idle();
      #3;
      rst = 1'b1;
      #1;
      chk("arst_wb_vld", {wb0_vld_o, wb1_vld_o}, 2'b00);
      chk("arst_wb0_fields", {wb0_rob_index_o, wb0_data_o, wb0_final_next_pc_o}, 100'd0);
      chk("arst_overflow", overflow_o, 1'b0);
      chk("arst_lsu_rdy", lsu_rdy_o, 1'b1);
      chk("arst_stalls", {alu1_stall_o, alu2_stall_o}, 2'b00);
      step();
      rst = 1'b0;
      drive(1, 4'hA, 6'd33, 64'h77, 1'b0, 32'h24);
      step();
      idle();
      step();
      chk("post_rst_wb0_vld", wb0_vld_o, 1'b1);
      chk("post_rst_wb0_rob", wb0_rob_index_o, 4'hA);
      chk("post_rst_wb1_vld", wb1_vld_o, 1'b0);
      step();
      chk("post_rst_drained", wb0_vld_o, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
